bounce_gen: RTL and testbench

- Synthesizable switch-bounce emulator. It takes a clean level input and, on every transition, drives a bursty, chattering output that eventually settles at the new level.
- Drives the raw switch input of the team's debouncer in hardware-in-loop tests and FPGA self-test builds.
- The burst contents are pseudo-random, from an LFSR, and deterministic for a given seed.

---
 rtl/bounce_pkg.sv | 8 +
 rtl/bounce_gen_if.sv | 7 +
 rtl/tick_prescaler.sv | 14 +
 rtl/bounce_gen.sv | 90 +++++++++
 tb/tb_bounce_gen.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/bounce_pkg.sv
// bounce_pkg: FSM state type and 16-bit Galois LFSR step shared by bounce_gen
package bounce_pkg;
  typedef enum logic [1:0] {IDLE, BOUNCE, SETTLE} state_t;
  localparam logic [15:0] LFSR_POLY = 16'hB400;
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {1'b0, s[15:1]} ^ (s[0] ? LFSR_POLY : 16'h0000);
  endfunction
endpackage

// File: rtl/bounce_gen_if.sv
// bounce_gen_if: control inputs and emulated switch outputs of bounce_gen
interface bounce_gen_if #(parameter int CW = 4);
  logic en, sw_clean, sw_bouncy, busy;
  logic [CW-1:0] bounce_cnt;
  modport master(output en, sw_clean, input sw_bouncy, busy, bounce_cnt);
  modport slave(input en, sw_clean, output sw_bouncy, busy, bounce_cnt);
endinterface

// File: rtl/tick_prescaler.sv
// tick_prescaler: mod-TICK_DIV counter with sync clear, tick on the last count
module tick_prescaler #(parameter int TICK_DIV = 1000) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);
  localparam int W = $clog2(TICK_DIV);
  logic [W-1:0] cnt;
  assign tick = cnt == W'(TICK_DIV - 1);
  always_ff @(posedge clk or negedge rst)
    if (!rst) cnt <= '0;
    else cnt <= (clr || tick) ? '0 : cnt + W'(1);
endmodule

// File: rtl/bounce_gen.sv
// bounce_gen: turns clean level changes into LFSR-driven chatter bursts that settle at the new level
module bounce_gen import bounce_pkg::*; #(
  parameter int          TICK_DIV     = 1000,
  parameter int          MAX_BOUNCES  = 8,
  parameter int          HOLD_BITS    = 2,
  parameter int          SETTLE_TICKS = 4,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input logic         clk,
  input logic         rst,
  bounce_gen_if.slave bus
);
  localparam int CW = $clog2(MAX_BOUNCES + 1);
  localparam int LB = $clog2(MAX_BOUNCES);
  localparam int HW = HOLD_BITS + 1;
  localparam int SW = $clog2(SETTLE_TICKS + 1);
  state_t state, state_nx;
  logic [15:0] lfsr;
  logic target, out, out_nx, clr, tick;
  logic [CW-1:0] cnt, cnt_nx, n, n_nx;
  logic [HW-1:0] hold, hold_nx, hold_new;
  logic [SW-1:0] settle, settle_nx;
  tick_prescaler #(.TICK_DIV(TICK_DIV)) u_pre (.clk(clk), .rst(rst), .clr(clr), .tick(tick));
  assign hold_new = HW'(lfsr[HOLD_BITS+7:8]) + HW'(1);
  always_comb begin
    state_nx = state;
    out_nx = out;
    cnt_nx = cnt;
    n_nx = n;
    hold_nx = hold;
    settle_nx = settle;
    clr = 1'b0;
    if (!bus.en) begin
      state_nx = IDLE;
      out_nx = bus.sw_clean;
    end else if (state == IDLE) begin
      if (target != out) begin
        state_nx = BOUNCE;
        out_nx = !out;
        cnt_nx = CW'(1);
        n_nx = CW'(lfsr[LB-1:0]) + CW'(1);
        hold_nx = hold_new;
        clr = 1'b1;
      end
    end else if (state == BOUNCE) begin
      if (tick) begin
        if (hold != HW'(1)) hold_nx = hold - HW'(1);
        else if (cnt < n) begin
          out_nx = !out;
          cnt_nx = cnt + CW'(1);
          hold_nx = hold_new;
        end else begin
          // settle level is forced from the very first settle cycle, whatever the burst parity
          state_nx = SETTLE;
          out_nx = target;
          settle_nx = SW'(SETTLE_TICKS);
        end
      end
    end else begin
      out_nx = target;
      if (tick) begin
        if (settle == SW'(1)) state_nx = IDLE;
        else settle_nx = settle - SW'(1);
      end
    end
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      lfsr <= LFSR_SEED;
      target <= 1'b0;
      out <= 1'b0;
      cnt <= '0;
      n <= '0;
      hold <= '0;
      settle <= '0;
    end else begin
      state <= state_nx;
      lfsr <= lfsr_next(lfsr);
      target <= bus.sw_clean;
      out <= out_nx;
      cnt <= cnt_nx;
      n <= n_nx;
      hold <= hold_nx;
      settle <= settle_nx;
    end
  assign bus.sw_bouncy = out;
  assign bus.busy = state != IDLE;
  assign bus.bounce_cnt = cnt;
endmodule

// File: tb/tb_bounce_gen.sv
// tb_bounce_gen: burst-level scoreboard and directed checks for bounce_gen
module tb_bounce_gen;
  localparam int TD = 4;
  localparam int MB = 4;
  localparam int HB = 1;
  localparam int ST = 2;
  localparam int CW = $clog2(MB + 1);
  typedef struct {
    int n;
    int len;
    int chg;
    int run;
    logic fin;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int cyc = 0;
  int total = 0;
  int bad = 0;
  logic lvl = 1'b0;
  logic mon_on = 1'b0;
  exp_t q[$];
  bounce_gen_if #(.CW(CW)) bus();
  bounce_gen #(.TICK_DIV(TD), .MAX_BOUNCES(MB), .HOLD_BITS(HB), .SETTLE_TICKS(ST), .LFSR_SEED(16'hACE1))
    dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk or negedge rst)
    if (!rst) cyc <= 0;
    else cyc <= cyc + 1;
  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  function automatic logic [15:0] lfsr_at(input int m);
    logic [15:0] s;
    s = 16'hACE1;
    for (int i = 0; i < m; i++) s = {1'b0, s[15:1]} ^ (s[0] ? 16'hB400 : 16'h0000);
    return s;
  endfunction
  // e is the clock edge (counted from reset release) at which the burst is entered
  function automatic exp_t model(input int e, input logic start, input logic fin);
    exp_t r;
    logic [15:0] l;
    logic after;
    int k, h, tog, tl;
    l = lfsr_at(e - 1);
    r.n = 1 + int'(l[1:0]);
    h = 1 + int'(l[8]);
    tog = 1;
    tl = e;
    k = e;
    while (1) begin
      k += TD * h;
      if (tog == r.n) break;
      tog++;
      tl = k;
      l = lfsr_at(k - 1);
      h = 1 + int'(l[8]);
    end
    after = start ^ r.n[0];
    r.len = k + TD * ST - e;
    r.fin = fin;
    r.chg = r.n + ((after != fin) ? 1 : 0);
    r.run = (after != fin) ? TD * ST : k + TD * ST - tl;
    return r;
  endfunction
  initial begin
    logic pb, po;
    int len, chg, run;
    exp_t e;
    pb = 1'b0;
    po = 1'b0;
    len = 0;
    chg = 0;
    run = 0;
    forever begin
      @(negedge clk);
      if (rst && mon_on) begin
        if (bus.busy) begin
          if (!pb) begin
            len = 0;
            chg = 0;
            run = 0;
          end
          len++;
          if (bus.sw_bouncy != po) begin
            chg++;
            run = 1;
          end else run++;
        end else if (pb) begin
          if (q.size() == 0) chk("spurious_burst", 1, 0);
          else begin
            e = q.pop_front();
            chk("burst_len", len, e.len);
            chk("burst_changes", chg, e.chg);
            chk("burst_final", int'(bus.sw_bouncy), int'(e.fin));
            chk("bounce_cnt", int'(bus.bounce_cnt), e.n);
            chk("settle_run", run, e.run);
          end
        end
      end
      pb = bus.busy;
      po = bus.sw_bouncy;
    end
  end
  task automatic wait_q();
    for (int i = 0; i < 300 && q.size() != 0; i++) @(negedge clk);
    if (q.size() != 0) begin
      chk("burst_timeout", q.size(), 0);
      q.delete();
    end
    @(negedge clk);
  endtask
  task automatic burst(input logic v, input logic rev);
    q.push_back(model(cyc + 2, lvl, rev ? lvl : v));
    bus.sw_clean = v;
    @(negedge clk);
    chk("busy_lag", int'(bus.busy), 0);
    @(negedge clk);
    chk("busy_rise", int'(bus.busy), 1);
    if (rev) begin
      @(negedge clk);
      bus.sw_clean = lvl;
    end
    wait_q();
    if (!rev) lvl = v;
  endtask
  initial begin
    int changes;
    logic prev;
    bus.en = 1'b0;
    bus.sw_clean = 1'b0;
    repeat (4) begin
      @(negedge clk);
      bus.sw_clean = ~bus.sw_clean;
    end
    @(negedge clk);
    chk("rst_out", int'(bus.sw_bouncy), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_cnt", int'(bus.bounce_cnt), 0);
    bus.sw_clean = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_rst_out", int'(bus.sw_bouncy), 0);
    chk("post_rst_busy", int'(bus.busy), 0);
    chk("post_rst_cnt", int'(bus.bounce_cnt), 0);
    bus.sw_clean = 1'b1;
    @(negedge clk);
    chk("pt_rise", int'(bus.sw_bouncy), 1);
    chk("pt_busy", int'(bus.busy), 0);
    bus.sw_clean = 1'b0;
    @(negedge clk);
    chk("pt_fall", int'(bus.sw_bouncy), 0);
    chk("pt_busy", int'(bus.busy), 0);
    bus.en = 1'b1;
    lvl = 1'b0;
    mon_on = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 4; i++) burst(~lvl, 1'b0);
    burst(1'b1, 1'b1);
    repeat (10) @(negedge clk);
    chk("rev_idle_busy", int'(bus.busy), 0);
    chk("rev_idle_out", int'(bus.sw_bouncy), 0);
    mon_on = 1'b0;
    bus.sw_clean = 1'b1;
    repeat (3) @(negedge clk);
    chk("abort_pre_busy", int'(bus.busy), 1);
    bus.en = 1'b0;
    @(negedge clk);
    chk("abort_busy", int'(bus.busy), 0);
    chk("abort_out", int'(bus.sw_bouncy), 1);
    changes = 0;
    prev = bus.sw_bouncy;
    repeat (10) begin
      @(negedge clk);
      if (bus.sw_bouncy != prev) changes++;
      prev = bus.sw_bouncy;
    end
    chk("abort_quiet", changes, 0);
    bus.en = 1'b1;
    @(negedge clk);
    bus.sw_clean = 1'b0;
    repeat (3) @(negedge clk);
    chk("rstmid_pre_busy", int'(bus.busy), 1);
    #2 rst = 1'b0;
    #1;
    chk("rstmid_out", int'(bus.sw_bouncy), 0);
    chk("rstmid_busy", int'(bus.busy), 0);
    chk("rstmid_cnt", int'(bus.bounce_cnt), 0);
    bus.sw_clean = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    lvl = 1'b0;
    mon_on = 1'b1;
    burst(1'b1, 1'b0);
    burst(1'b0, 1'b0);
    chk("queue_left", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
